pc_redirect: RTL and testbench
==============================

Name: pc_redirect

Overview:
- Consumer end of the branch comparator's result `b`: the PC sequencer in the rysy core.
- Holds the fetch PC and advances it by 4 each cycle.
- On a taken branch (cmp `b`=1 with a conditional branch in execute) or an unconditional jump, loads the execute-stage target, then asserts flush for FLUSH_CYCLES pipeline advances to kill wrong-path instructions.
- Detects misaligned targets and parks in an error state.

Parameters:
- XLEN, 32, width of PC and target (matches `REG_LEN).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of non-stalled cycles flush stays high after a redirect; legal range 1..15.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline freeze (e.g. memory wait); PC holds.
- br_valid  in  1  execute stage holds a conditional branch (beq..bgeu).
- b  in  1  branch condition from the comparator; meaningful only when br_valid=1.
- jmp_valid  in  1  execute stage holds jal/jalr.
- tgt  in  XLEN  target address from the execute-stage adder.
- pc  out  XLEN  current fetch address (registered).
- pc_valid  out  1  fetch request valid.
- redirect  out  1  one-cycle pulse: pc was just loaded from tgt.
- flush  out  1  kill fetch/decode instructions younger than execute.
- misalign  out  1  sticky: taken target had tgt[1:0]!=0.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, async): state=BOOT, pc=RESET_PC, pc_valid=0, redirect=0, flush=0, misalign=0, flush counter=0.
- take = (br_valid & b) | jmp_valid. Evaluated only in RUN. b is ignored when br_valid=0.
- States:
  - BOOT: one cycle after reset release. pc_valid goes to 1 at the next edge. Next state RUN. pc unchanged.
  - RUN, priority order:
    1. take & tgt[1:0]!=0 -> ERR: misalign<=1, pc_valid<=0, pc unchanged.
    2. take -> pc<=tgt, redirect<=1, flush<=1, cnt<=FLUSH_CYCLES-1. Next state FLUSH if FLUSH_CYCLES>1, else RUN with flush high for that one cycle only.
    3. stall -> pc holds, all pulses 0.
    4. Otherwise pc<=pc+4, modulo 2^XLEN (wraps 0xFFFF_FFFC -> 0x0).
  - Take beats stall: a redirect is never lost to a stall in the same cycle.
  - FLUSH:
    - flush=1. redirect=0 after its first cycle.
    - br_valid, jmp_valid and b are ignored (they come from killed instructions).
    - Non-stalled cycle: pc<=pc+4 (fetching the target stream); if cnt==0 go to RUN with flush<=0, else cnt<=cnt-1.
    - Stalled cycle: pc and cnt hold, flush stays 1.
  - ERR: pc holds, pc_valid=0, flush=0, misalign=1. Left only by reset.
- Latency: take sampled at edge N -> pc=tgt and redirect=1 visible after edge N. flush is high for exactly FLUSH_CYCLES non-stalled cycles starting then.
- Reset mid-FLUSH or in ERR returns to BOOT immediately, with all outputs at reset values.
- Simultaneous br_valid & jmp_valid: treated as take. tgt is the single shared target.
- br_valid=1 with b=0: not taken; normal increment or stall.

Optional Feature:
- Macro: RYSY_BR_STATS_EN.
- When defined, adds two outputs:
  - br_cnt (32): counts RUN cycles with br_valid|jmp_valid and stall=0.
  - br_taken_cnt (32): counts RUN cycles with take=1, including the misaligned take.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0x100, no branches, stall=0:
  - BOOT cycle: pc=0x100, pc_valid=0.
  - Then pc=0x100, 0x104, 0x108 with pc_valid=1.
- In RUN at pc=0x10, drive br_valid=1, b=1, tgt=0x200 for one cycle:
  - Next cycle: pc=0x200, redirect=1, flush=1.
  - Following cycle: pc=0x204, flush=1, redirect=0.
  - Then pc=0x208, flush=0 (FLUSH_CYCLES=2).
- br_valid=1, b=0, tgt=0x200 at pc=0x10 -> pc=0x14, no redirect, no flush.
- jmp_valid=1 with stall=1, tgt=0x40:
  - pc=0x40, redirect=1.
  - Then hold stall 3 cycles: flush stays 1, pc stays 0x40.
  - After stall drops: 2 cycles of flush with pc 0x40 -> 0x44 -> 0x48.
- Taken branch with tgt=0x202:
  - misalign=1 and pc_valid=0; pc holds its previous value indefinitely.
  - Further br_valid/jmp_valid have no effect.
  - rst_n pulse low clears misalign and returns to BOOT.
- Run from pc=0xFFFF_FFF8 -> 0xFFFF_FFFC -> 0x0000_0000. With RYSY_BR_STATS_EN: 3 taken and 2 not-taken branches -> br_cnt=5, br_taken_cnt=3.

Source files
------------

// File: rtl/pc_redirect.sv
// pc_redirect -- PC sequencer for the rysy core.
//
// Holds the fetch PC and steps it by 4 every non-stalled cycle. A taken
// conditional branch (br_valid & b) or a jump (jmp_valid) in execute loads the
// execute-stage target, pulses redirect, and holds flush high for FLUSH_CYCLES
// non-stalled cycles so wrong-path instructions in fetch/decode are killed.
// A taken target with tgt[1:0] != 0 parks the block in ERR until reset.
//
// Optional feature (macro RYSY_BR_STATS_EN): adds the saturating branch
// counters br_cnt and br_taken_cnt.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   stall        pipeline freeze; PC holds
//   br_valid     execute holds a conditional branch
//   b            comparator result, qualified by br_valid
//   jmp_valid    execute holds jal/jalr
//   tgt          execute-stage target address
//   pc           registered fetch address
//   pc_valid     fetch request valid
//   redirect     one-cycle pulse: pc was just loaded from tgt
//   flush        kill instructions younger than execute
//   misalign     sticky misaligned-target flag
//   br_cnt       (stats) RUN cycles with a branch/jump and no stall
//   br_taken_cnt (stats) RUN cycles with a take, misaligned included

module pc_redirect #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_PC     = '0,
    parameter int unsigned      FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_valid,
    input  logic            b,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] tgt,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            redirect,
    output logic            flush,
`ifdef RYSY_BR_STATS_EN
    output logic            misalign,
    output logic [31:0]     br_cnt,
    output logic [31:0]     br_taken_cnt
`else
    output logic            misalign
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, ERR} state_e;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            redirect_q, redirect_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    logic [3:0]      cnt_q, cnt_d;

    logic take;
    assign take = (br_valid & b) | jmp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        redirect_d = 1'b0;
        flush_d    = flush_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            BOOT: begin
                pc_valid_d = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                flush_d = 1'b0;
                // Take is checked before stall so a redirect is never dropped.
                if (take && tgt[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                    pc_valid_d = 1'b0;
                    state_d    = ERR;
                end else if (take) begin
                    pc_d       = tgt;
                    redirect_d = 1'b1;
                    flush_d    = 1'b1;
                    cnt_d      = CNT_INIT;
                    // With a single flush cycle, RUN clears flush on the next edge.
                    state_d    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (!stall) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            FLUSH: begin
                // Branch inputs here belong to killed instructions.
                if (!stall) begin
                    pc_d = pc_q + XLEN'(4);
                    if (cnt_q == 4'd0) begin
                        flush_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ERR: begin
                pc_valid_d = 1'b0;
                flush_d    = 1'b0;
                misalign_d = 1'b1;
            end
            default: state_d = BOOT;
        endcase
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign redirect = redirect_q;
    assign flush    = flush_q;
    assign misalign = misalign_q;

`ifdef RYSY_BR_STATS_EN
    logic [31:0] br_cnt_q, br_taken_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
        end else if (state_q == RUN) begin
            if ((br_valid | jmp_valid) && !stall && br_cnt_q != 32'hFFFF_FFFF)
                br_cnt_q <= br_cnt_q + 32'd1;
            if (take && br_taken_cnt_q != 32'hFFFF_FFFF)
                br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
        end
    end

    assign br_cnt       = br_cnt_q;
    assign br_taken_cnt = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect.sv
module tb_pc_redirect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_valid, b, jmp_valid;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        pc_valid, redirect, flush, misalign;
`ifdef RYSY_BR_STATS_EN
    logic [31:0] br_cnt, br_taken_cnt;
`endif

    always #5 clk = ~clk;

    pc_redirect #(.XLEN(32), .RESET_PC(32'h100), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .b(b),
        .jmp_valid(jmp_valid), .tgt(tgt), .pc(pc), .pc_valid(pc_valid),
        .redirect(redirect), .flush(flush),
`ifdef RYSY_BR_STATS_EN
        .misalign(misalign), .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
`else
        .misalign(misalign)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        pv, rd, fl, ma;
    } exp_t;

    typedef struct packed {
        logic        s, bv, bb, jv;
        logic [31:0] t;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb.pop_front();
        checks++;
        if ({pc, pc_valid, redirect, flush, misalign} !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b r=%b f=%b m=%b, want pc=%h v=%b r=%b f=%b m=%b",
                     nm, pc, pc_valid, redirect, flush, misalign, e.pc, e.pv, e.rd, e.fl, e.ma);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, expect e after the next rising edge.
    task automatic cyc(input logic s, bv, bb, jv, input logic [31:0] t, input exp_t e,
                       input string nm);
        stall = s; br_valid = bv; b = bb; jmp_valid = jv; tgt = t;
        sb.push_back(e);
        @(negedge clk);
        check(nm);
    endtask

    task automatic idle(input exp_t e, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e, nm);
    endtask

    // Asynchronous reset pulse, then BOOT-state check before any edge.
    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        #1;
        sb.push_back('{32'h100, 1'b0, 1'b0, 1'b0, 1'b0});
        check({nm, "_async"});
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{32'h100, 1'b0, 1'b0, 1'b0, 1'b0});
        check({nm, "_boot"});
    endtask

    initial begin
        // Main directed table, applied from the BOOT cycle onwards.
        vq.push_back('{0,0,0,0,32'h0,   '{32'h100,1,0,0,0}});  // BOOT -> RUN
        vq.push_back('{0,0,0,0,32'h0,   '{32'h104,1,0,0,0}});
        vq.push_back('{0,0,0,0,32'h0,   '{32'h108,1,0,0,0}});
        vq.push_back('{0,0,0,1,32'h8,   '{32'h008,1,1,1,0}});  // jump
        vq.push_back('{0,0,0,0,32'h0,   '{32'h00c,1,0,1,0}});
        vq.push_back('{0,0,0,0,32'h0,   '{32'h010,1,0,0,0}});
        vq.push_back('{0,1,1,0,32'h200, '{32'h200,1,1,1,0}});  // taken branch
        vq.push_back('{0,1,1,0,32'h300, '{32'h204,1,0,1,0}});  // ignored in flush
        vq.push_back('{0,0,0,0,32'h0,   '{32'h208,1,0,0,0}});
        vq.push_back('{0,0,0,1,32'h8,   '{32'h008,1,1,1,0}});
        vq.push_back('{0,0,0,0,32'h0,   '{32'h00c,1,0,1,0}});
        vq.push_back('{0,0,0,0,32'h0,   '{32'h010,1,0,0,0}});
        vq.push_back('{0,1,0,0,32'h200, '{32'h014,1,0,0,0}});  // not taken
        vq.push_back('{1,0,0,0,32'h0,   '{32'h014,1,0,0,0}});  // stall in RUN
        vq.push_back('{1,0,0,1,32'h40,  '{32'h040,1,1,1,0}});  // take beats stall
        vq.push_back('{1,0,0,0,32'h0,   '{32'h040,1,0,1,0}});
        vq.push_back('{1,0,0,0,32'h0,   '{32'h040,1,0,1,0}});
        vq.push_back('{1,0,0,0,32'h0,   '{32'h040,1,0,1,0}});
        vq.push_back('{0,0,0,0,32'h0,   '{32'h044,1,0,1,0}});
        vq.push_back('{0,0,0,0,32'h0,   '{32'h048,1,0,0,0}});
        vq.push_back('{0,1,1,1,32'h80,  '{32'h080,1,1,1,0}});  // br & jmp together
        vq.push_back('{0,0,0,0,32'h0,   '{32'h084,1,0,1,0}});
        vq.push_back('{0,0,0,0,32'h0,   '{32'h088,1,0,0,0}});
        vq.push_back('{0,0,1,0,32'h200, '{32'h08c,1,0,0,0}});  // b without br_valid
        vq.push_back('{0,1,1,0,32'h202, '{32'h08c,0,0,0,1}});  // misaligned -> ERR
        vq.push_back('{0,0,0,1,32'h100, '{32'h08c,0,0,0,1}});
        vq.push_back('{0,1,1,0,32'h200, '{32'h08c,0,0,0,1}});
        vq.push_back('{1,0,0,0,32'h0,   '{32'h08c,0,0,0,1}});

        rst_n = 1'b0; stall = 0; br_valid = 0; b = 0; jmp_valid = 0; tgt = '0;
        @(negedge clk);
        sb.push_back('{32'h100, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset");
        rst_n = 1'b1;
        sb.push_back('{32'h100, 1'b0, 1'b0, 1'b0, 1'b0});
        check("boot");

        for (int i = 0; i < vq.size(); i++)
            cyc(vq[i].s, vq[i].bv, vq[i].bb, vq[i].jv, vq[i].t, vq[i].e, $sformatf("vec%0d", i));

        // Reset out of ERR.
        do_reset("rst_err");
        idle('{32'h100, 1, 0, 0, 0}, "err_rec0");
        idle('{32'h104, 1, 0, 0, 0}, "err_rec1");

        // Wrap-around: land on 0xFFFF_FFF8 and run through the top of the address space.
        cyc(0, 0, 0, 1, 32'hFFFF_FFF8, '{32'hFFFF_FFF8, 1, 1, 1, 0}, "wrap0");
        idle('{32'hFFFF_FFFC, 1, 0, 1, 0}, "wrap1");
        idle('{32'h0000_0000, 1, 0, 0, 0}, "wrap2");
        idle('{32'h0000_0004, 1, 0, 0, 0}, "wrap3");

        // Reset in the middle of a flush window.
        cyc(0, 1, 1, 0, 32'h400, '{32'h400, 1, 1, 1, 0}, "midflush0");
        do_reset("rst_flush");
        idle('{32'h100, 1, 0, 0, 0}, "midflush1");

`ifdef RYSY_BR_STATS_EN
        // Fresh reset, then 2 not-taken and 3 taken branches in RUN.
        do_reset("rst_stats");
        idle('{32'h100, 1, 0, 0, 0}, "st0");
        cyc(0, 1, 0, 0, 32'h200, '{32'h104, 1, 0, 0, 0}, "st_nt0");
        cyc(0, 1, 0, 0, 32'h200, '{32'h108, 1, 0, 0, 0}, "st_nt1");
        cyc(0, 0, 0, 1, 32'h200, '{32'h200, 1, 1, 1, 0}, "st_t0");
        idle('{32'h204, 1, 0, 1, 0}, "st1");
        idle('{32'h208, 1, 0, 0, 0}, "st2");
        cyc(0, 1, 1, 0, 32'h300, '{32'h300, 1, 1, 1, 0}, "st_t1");
        idle('{32'h304, 1, 0, 1, 0}, "st3");
        idle('{32'h308, 1, 0, 0, 0}, "st4");
        cyc(0, 0, 0, 1, 32'h500, '{32'h500, 1, 1, 1, 0}, "st_t2");
        idle('{32'h504, 1, 0, 1, 0}, "st5");
        idle('{32'h508, 1, 0, 0, 0}, "st6");
        checks++;
        if (br_cnt !== 32'd5) begin
            errors++;
            $display("FAIL br_cnt: got %0d want 5", br_cnt);
        end
        checks++;
        if (br_taken_cnt !== 32'd3) begin
            errors++;
            $display("FAIL br_taken_cnt: got %0d want 3", br_taken_cnt);
        end
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
